alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle control sequencer that drives the DataPath's control inputs (register out/in strobes, MAR/MDR/IR/Y/Z/HI/LO enables, IncPC, Read, ALU opcode) through fetch and execute. It initiates the control interface the datapath responds to, replacing hand-timed bench stimulus. It supports three-register ALU ops and the MUL/DIV HI/LO sequence.

## Interface
- MEM_WAIT, 0, extra cycles T1 holds Read/MDRin for memory latency (0–15)
- Clock  in  1  system clock, rising edge
- Clear  in  1  reset; one clock; reset is asynchronous and active-low
- Run  in  1  level; sequencer fetches while high
- IR  in  32  instruction register contents from DataPath
- Rout  out  16  one-hot general-register output select (bit n = Rn out)
- Rin  out  16  one-hot general-register load select
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin  out  1 each  Z/HI/LO strobes
- ALU_op  out  5  ALU operation code
- Done  out  1  high in the final execute cycle of each instruction
- Illegal  out  1  high while in FAULT
- Retired  out  16  count of completed instructions

## Operation
- Fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Supported op: ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT.
- IDLE: all strobes 0; Run=1 → T0.
- T0: PCout, MARin, IncPC, ZLowIn. T1: ZLowout, PCin, Read, MDRin. T2: MDRout, IRin.
- T3: decode op; unsupported → FAULT without asserting strobes. Otherwise Rout=onehot(Rb), Yin.
- T4: Rout=onehot(Rc), ALU_op=op, ZLowIn; MUL/DIV also ZHighIn.
- T5: ZLowout; ADD/SUB/AND/OR: Rin=onehot(Ra), Done. MUL/DIV: LOin.
- T6 (MUL/DIV only): ZHighout, HIin, Done.
- At end of final state: Retired += 1, wrapping 0xFFFF→0x0000. Run=1 → T0, else IDLE.
- FAULT: Illegal=1, all strobes 0; exit only by Clear.
- ALU_op is 0 outside T4.

## Timing
- All strobes are Moore outputs decoded from the current state, held the full cycle.
- Reset: state=IDLE, T1 wait counter=0, Retired=0, all outputs 0. Clear is asynchronous: outputs drop immediately even mid-instruction. No partial write is retried.
- T1 lasts 1+MEM_WAIT cycles. The wait counter is loaded on T1 entry and T1 exits when it reaches 0.
- Latency with MEM_WAIT=0, Run held high: ALU op 6 cycles (T0–T5), MUL/DIV 7 (T0–T6), back-to-back with no IDLE gap.
- Run falling mid-instruction has no effect until the instruction's final cycle.
- IR is sampled only in T3–T6. IR changes after T2 must not occur, since the datapath holds IR.
- Ra=Rb or Ra=0 is decoded normally. Write protection is not provided.

## Structure
- Shared package `cpu_pkg` holds opcode localparams, field bit positions, state encoding, and the onehot16 decode function.
- Sub-module `reg_select_decoder` maps a 4-bit register index to a 16-bit one-hot output, with an enable input. It is instantiated twice: once for Rin and once for Rout.

## Test plan
- Reset mid-T4 (Clear low async) → all outputs 0 within the same cycle; Retired=0; state IDLE after release.
- IR=0x28918000 (AND R1,R2,R3), MEM_WAIT=0 → T3 Rout=0x0004 Yin; T4 Rout=0x0008 ALU_op=00101 ZLowIn; T5 ZLowout Rin=0x0002 Done; Retired=1.
- IR=0x80228000 (DIV R4,R5) → T4 Rout=0x0020 ALU_op=10000 ZLowIn ZHighIn; T5 ZLowout LOin; T6 ZHighout HIin Done; 7 cycles total.
- MEM_WAIT=3 → Read and MDRin high for exactly 4 consecutive cycles; ADD completes in 9 cycles.
- IR opcode 11111 → FAULT after T3, Illegal=1, no Yin/Rout ever asserted; Run toggling is ignored until Clear.
- Run held high for 65536 ADDs (counter preset by force) → Retired wraps 0xFFFF→0x0000 with no gap cycle between instructions.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Provides:
//   - opcode values for the supported instruction set
//   - bit positions of the op/Ra/Rb/Rc fields within IR
//   - the sequencer state encoding
//   - onehot16(): 4-bit register index -> 16-bit one-hot select
//   - opcode class helpers used by decode
package cpu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_FAULT = 4'd8
    } state_e;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

    // Three-register ops finish in T5 with a register write.
    function automatic logic is_alu3(input logic [4:0] op);
        is_alu3 = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // MUL/DIV produce a 64-bit result split into LO (T5) and HI (T6).
    function automatic logic is_muldiv(input logic [4:0] op);
        is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register select decoder.
// Ports:
//   en     in   1   when low the output is all zeros
//   idx    in   4   general-register index
//   onehot out  16  one-hot select (bit n = register n)
module reg_select_decoder
    import cpu_pkg::*;
(
    input  logic        en,
    input  logic [3:0]  idx,
    output logic [15:0] onehot
);

    assign onehot = en ? onehot16(idx) : 16'h0000;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the DataPath: fetch (T0-T2) followed by
// execute (T3-T5, plus T6 for MUL/DIV). All strobes are Moore outputs decoded
// from the current state.
// Parameter:
//   MEM_WAIT  extra cycles T1 holds Read/MDRin (0..15)
// Ports:
//   Clock     in   1   rising-edge clock
//   Clear     in   1   asynchronous active-low reset
//   Run       in   1   level; fetch continues while high
//   IR        in   32  instruction register contents
//   Rout/Rin  out  16  one-hot general register out/load selects
//   PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin   out 1 each
//   ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin              out 1 each
//   ALU_op    out  5   ALU operation code, valid only in T4
//   Done      out  1   final execute cycle of an instruction
//   Illegal   out  1   unsupported opcode trapped (FAULT)
//   Retired   out  16  completed instruction count, wrapping
module alu_op_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic [31:0] IR,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  ALU_op,
    output logic        Done,
    output logic        Illegal,
    output logic [15:0] Retired
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] retired_q, retired_d;

    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        op_alu3, op_muldiv, op_ok;
    logic        rout_en, rin_en;
    logic [3:0]  rout_idx;
    logic        unused_ir;

    assign op        = IR[OP_MSB:OP_LSB];
    assign ra        = IR[RA_MSB:RA_LSB];
    assign rb        = IR[RB_MSB:RB_LSB];
    assign rc        = IR[RC_MSB:RC_LSB];
    assign unused_ir = ^IR[RC_LSB-1:0];
    assign op_alu3   = is_alu3(op);
    assign op_muldiv = is_muldiv(op);
    assign op_ok     = op_alu3 || op_muldiv;

    // State register
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE:  if (Run) state_d = ST_T0;
            ST_T0: begin
                state_d = ST_T1;
                wait_d  = WAIT_LOAD;   // T1 runs 1 + MEM_WAIT cycles
            end
            ST_T1: begin
                if (wait_q == 4'd0) state_d = ST_T2;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_T2:    state_d = ST_T3;
            ST_T3:    state_d = op_ok ? ST_T4 : ST_FAULT;
            ST_T4:    state_d = ST_T5;
            ST_T5: begin
                if (op_muldiv) state_d = ST_T6;
                else           state_d = Run ? ST_T0 : ST_IDLE;
            end
            ST_T6:    state_d = Run ? ST_T0 : ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;  // only Clear leaves FAULT
            default:  state_d = ST_IDLE;
        endcase
    end

    // Done marks the last cycle, so the count advances on the same edge
    // that leaves the instruction.
    always_comb begin
        retired_d = retired_q;
        if (Done) retired_d = retired_q + 16'd1;
    end

    // Output decode
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        ZLowout  = 1'b0;
        ZHighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ALU_op   = 5'd0;
        Done     = 1'b0;
        Illegal  = 1'b0;
        rout_en  = 1'b0;
        rout_idx = 4'd0;
        rin_en   = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            ST_T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                // An unsupported opcode heads to FAULT with nothing driven.
                if (op_ok) begin
                    rout_en  = 1'b1;
                    rout_idx = rb;
                    Yin      = 1'b1;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                ALU_op   = op;
                ZLowIn   = 1'b1;
                ZHighIn  = op_muldiv;
            end
            ST_T5: begin
                ZLowout = 1'b1;
                if (op_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end
            end
            ST_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
            end
            ST_FAULT: Illegal = 1'b1;
            default: ;
        endcase
    end

    reg_select_decoder u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (Rout)
    );

    reg_select_decoder u_rin_dec (
        .en     (rin_en),
        .idx    (ra),
        .onehot (Rin)
    );

    assign Retired = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        Clock = 1'b0;
    logic        Clear, Run, Run1;
    logic [31:0] IR, IR1;

    logic [15:0] Rout, Rin, Retired;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
    logic ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, Done, Illegal;
    logic [4:0]  ALU_op;

    logic [15:0] Rout1, Rin1, Retired1;
    logic PCout1, PCin1, IncPC1, MARin1, Read1, MDRin1, MDRout1, IRin1, Yin1;
    logic ZLowIn1, ZHighIn1, ZLowout1, ZHighout1, HIin1, LOin1, Done1, Illegal1;
    logic [4:0]  ALU_op1;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    alu_op_sequencer #(.MEM_WAIT(0)) dut0 (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
        .Rout(Rout), .Rin(Rin), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowout(ZLowout),
        .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin), .ALU_op(ALU_op),
        .Done(Done), .Illegal(Illegal), .Retired(Retired)
    );

    alu_op_sequencer #(.MEM_WAIT(3)) dut1 (
        .Clock(Clock), .Clear(Clear), .Run(Run1), .IR(IR1),
        .Rout(Rout1), .Rin(Rin1), .PCout(PCout1), .PCin(PCin1), .IncPC(IncPC1),
        .MARin(MARin1), .Read(Read1), .MDRin(MDRin1), .MDRout(MDRout1), .IRin(IRin1),
        .Yin(Yin1), .ZLowIn(ZLowIn1), .ZHighIn(ZHighIn1), .ZLowout(ZLowout1),
        .ZHighout(ZHighout1), .HIin(HIin1), .LOin(LOin1), .ALU_op(ALU_op1),
        .Done(Done1), .Illegal(Illegal1), .Retired(Retired1)
    );

    // Strobe bundle of dut0, MSB first
    wire [16:0] strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
                        ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, Done, Illegal};

    localparam logic [16:0] B_PCOUT  = 17'h10000;
    localparam logic [16:0] B_PCIN   = 17'h08000;
    localparam logic [16:0] B_INCPC  = 17'h04000;
    localparam logic [16:0] B_MARIN  = 17'h02000;
    localparam logic [16:0] B_READ   = 17'h01000;
    localparam logic [16:0] B_MDRIN  = 17'h00800;
    localparam logic [16:0] B_MDROUT = 17'h00400;
    localparam logic [16:0] B_IRIN   = 17'h00200;
    localparam logic [16:0] B_YIN    = 17'h00100;
    localparam logic [16:0] B_ZLIN   = 17'h00080;
    localparam logic [16:0] B_ZHIN   = 17'h00040;
    localparam logic [16:0] B_ZLOUT  = 17'h00020;
    localparam logic [16:0] B_ZHOUT  = 17'h00010;
    localparam logic [16:0] B_HIIN   = 17'h00008;
    localparam logic [16:0] B_LOIN   = 17'h00004;
    localparam logic [16:0] B_DONE   = 17'h00002;
    localparam logic [16:0] B_ILL    = 17'h00001;

    localparam logic [16:0] S_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
    localparam logic [16:0] S_T1 = B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [16:0] S_T2 = B_MDROUT | B_IRIN;

    localparam logic [31:0] IR_AND = 32'h28918000;                          // AND R1,R2,R3
    localparam logic [31:0] IR_DIV = 32'h80228000;                          // DIV R4,R5
    localparam logic [31:0] IR_ADD = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};   // ADD R1,R2,R3
    localparam logic [31:0] IR_BAD = 32'hF8000000;                          // opcode 11111

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and compare the whole control word.
    task automatic cyc(input string tag, input logic [16:0] es, input logic [15:0] erout,
                       input logic [15:0] erin, input logic [4:0] eop);
        @(negedge Clock);
        chk({tag, "_strobes"}, 32'(strb), 32'(es));
        chk({tag, "_rout"}, 32'(Rout), 32'(erout));
        chk({tag, "_rin"}, 32'(Rin), 32'(erin));
        chk({tag, "_aluop"}, 32'(ALU_op), 32'(eop));
        $display("step %s strobes=%05h rout=%04h rin=%04h op=%02h retired=%04h",
                 tag, strb, Rout, Rin, ALU_op, Retired);
    endtask

    initial begin
        int rd_cnt, first_rd, last_rd, done_at;

        Clear = 1'b0; Run = 1'b0; Run1 = 1'b0; IR = 32'h0; IR1 = 32'h0;

        // Reset state
        repeat (2) @(negedge Clock);
        chk("rst_strobes", 32'(strb), 32'h0);
        chk("rst_rout", 32'(Rout), 32'h0);
        chk("rst_retired", 32'(Retired), 32'h0);
        Clear = 1'b1;

        // AND R1,R2,R3
        IR = IR_AND; Run = 1'b1;
        cyc("and_t0", S_T0, 16'h0, 16'h0, 5'd0);
        cyc("and_t1", S_T1, 16'h0, 16'h0, 5'd0);
        cyc("and_t2", S_T2, 16'h0, 16'h0, 5'd0);
        cyc("and_t3", B_YIN, 16'h0004, 16'h0, 5'd0);
        cyc("and_t4", B_ZLIN, 16'h0008, 16'h0, 5'b00101);
        Run = 1'b0;
        cyc("and_t5", B_ZLOUT | B_DONE, 16'h0, 16'h0002, 5'd0);
        cyc("and_idle", 17'h0, 16'h0, 16'h0, 5'd0);
        chk("and_retired", 32'(Retired), 32'd1);

        // DIV R4,R5 with Run dropped mid-instruction
        IR = IR_DIV; Run = 1'b1;
        cyc("div_t0", S_T0, 16'h0, 16'h0, 5'd0);
        cyc("div_t1", S_T1, 16'h0, 16'h0, 5'd0);
        cyc("div_t2", S_T2, 16'h0, 16'h0, 5'd0);
        cyc("div_t3", B_YIN, 16'h0010, 16'h0, 5'd0);
        Run = 1'b0;
        cyc("div_t4", B_ZLIN | B_ZHIN, 16'h0020, 16'h0, 5'b10000);
        cyc("div_t5", B_ZLOUT | B_LOIN, 16'h0, 16'h0, 5'd0);
        cyc("div_t6", B_ZHOUT | B_HIIN | B_DONE, 16'h0, 16'h0, 5'd0);
        cyc("div_idle", 17'h0, 16'h0, 16'h0, 5'd0);
        chk("div_retired", 32'(Retired), 32'd2);

        // Asynchronous Clear in the middle of T4
        IR = IR_ADD; Run = 1'b1;
        cyc("rst4_t0", S_T0, 16'h0, 16'h0, 5'd0);
        cyc("rst4_t1", S_T1, 16'h0, 16'h0, 5'd0);
        cyc("rst4_t2", S_T2, 16'h0, 16'h0, 5'd0);
        cyc("rst4_t3", B_YIN, 16'h0004, 16'h0, 5'd0);
        cyc("rst4_t4", B_ZLIN, 16'h0008, 16'h0, 5'b00011);
        #2 Clear = 1'b0;
        #1;
        chk("rst4_async_strobes", 32'(strb), 32'h0);
        chk("rst4_async_rout", 32'(Rout), 32'h0);
        chk("rst4_async_aluop", 32'(ALU_op), 32'h0);
        chk("rst4_async_retired", 32'(Retired), 32'h0);
        Run = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        cyc("rst4_idle", 17'h0, 16'h0, 16'h0, 5'd0);
        chk("rst4_retired", 32'(Retired), 32'h0);

        // Unsupported opcode traps in FAULT; Run toggling ignored
        IR = IR_BAD; Run = 1'b1;
        cyc("ill_t0", S_T0, 16'h0, 16'h0, 5'd0);
        cyc("ill_t1", S_T1, 16'h0, 16'h0, 5'd0);
        cyc("ill_t2", S_T2, 16'h0, 16'h0, 5'd0);
        cyc("ill_t3", 17'h0, 16'h0, 16'h0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            cyc("ill_fault", B_ILL, 16'h0, 16'h0, 5'd0);
            Run = ~Run;
        end
        chk("ill_retired", 32'(Retired), 32'h0);
        Clear = 1'b0; Run = 1'b0;
        #1;
        chk("ill_clear", 32'(strb), 32'h0);
        @(negedge Clock);
        Clear = 1'b1;
        cyc("ill_idle", 17'h0, 16'h0, 16'h0, 5'd0);

        // Retired wrap with back-to-back ADDs
        force dut0.retired_q = 16'hFFFE;
        @(negedge Clock);
        release dut0.retired_q;
        #1;
        chk("wrap_preset", 32'(Retired), 32'h0000FFFE);
        IR = IR_ADD; Run = 1'b1;
        cyc("wrap_a_t0", S_T0, 16'h0, 16'h0, 5'd0);
        cyc("wrap_a_t1", S_T1, 16'h0, 16'h0, 5'd0);
        cyc("wrap_a_t2", S_T2, 16'h0, 16'h0, 5'd0);
        cyc("wrap_a_t3", B_YIN, 16'h0004, 16'h0, 5'd0);
        cyc("wrap_a_t4", B_ZLIN, 16'h0008, 16'h0, 5'b00011);
        cyc("wrap_a_t5", B_ZLOUT | B_DONE, 16'h0, 16'h0002, 5'd0);
        cyc("wrap_b_t0", S_T0, 16'h0, 16'h0, 5'd0);
        chk("wrap_mid_retired", 32'(Retired), 32'h0000FFFF);
        cyc("wrap_b_t1", S_T1, 16'h0, 16'h0, 5'd0);
        cyc("wrap_b_t2", S_T2, 16'h0, 16'h0, 5'd0);
        cyc("wrap_b_t3", B_YIN, 16'h0004, 16'h0, 5'd0);
        cyc("wrap_b_t4", B_ZLIN, 16'h0008, 16'h0, 5'b00011);
        Run = 1'b0;
        cyc("wrap_b_t5", B_ZLOUT | B_DONE, 16'h0, 16'h0002, 5'd0);
        cyc("wrap_idle", 17'h0, 16'h0, 16'h0, 5'd0);
        chk("wrap_retired", 32'(Retired), 32'h0);

        // MEM_WAIT=3: T1 stretched to 4 cycles, ADD takes 9
        rd_cnt = 0; first_rd = -1; last_rd = -1; done_at = -1;
        IR1 = IR_ADD; Run1 = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge Clock);
            if (Read1 && MDRin1) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = n;
                last_rd = n;
            end
            if (Done1) begin
                done_at = n;
                break;
            end
        end
        Run1 = 1'b0;
        $display("step memwait done_at=%0d read_cycles=%0d span=%0d",
                 done_at, rd_cnt, last_rd - first_rd + 1);
        chk("mw_latency", 32'(done_at), 32'd9);
        chk("mw_read_cycles", 32'(rd_cnt), 32'd4);
        chk("mw_read_span", 32'(last_rd - first_rd + 1), 32'd4);
        @(negedge Clock);
        chk("mw_retired", 32'(Retired1), 32'd1);
        chk("mw_idle", 32'(Read1 | PCout1 | Done1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
